aes_result_buffer: RTL and testbench

- Downstream of the AES cipher core: captures each 128-bit ciphertext block on the core's one-cycle done pulse.
- Queues up to DEPTH blocks.
- Streams them out as OUT_W-bit words over a valid/ready interface, most-significant word first.
- Exports a full flag so the input side can withhold the next load.

---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_result_buffer_if.sv | 25 ++
 rtl/aes_word_serializer.sv | 53 +++++
 rtl/aes_result_buffer.sv | 88 ++++++++
 tb/tb_aes_result_buffer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types used by the result buffer and its word serializer.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Index width that stays legal when there is only one element to select.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_result_buffer_if.sv
// Word-stream valid/ready bus carrying ciphertext out of the result buffer.
interface aes_result_buffer_if #(
  parameter int unsigned OUT_W = 32
);

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/aes_word_serializer.sv
// Slices the head block into OUT_W-bit words, most-significant first, and
// signals pop when the final word of the block is accepted.
module aes_word_serializer
  import aes_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  aes_block_t       head,
  input  logic             head_valid,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             pop
);

  localparam int unsigned NWORDS = AES_BLOCK_W / OUT_W;
  localparam int unsigned IDX_W  = idx_width(NWORDS);

  logic [NWORDS-1:0][OUT_W-1:0] words;
  logic [IDX_W-1:0]             word_idx_q, word_idx_d;
  logic [IDX_W-1:0]             sel;
  logic                         accept;

  assign words = head;

  always_comb begin
    out_valid  = head_valid;
    out_last   = head_valid && (word_idx_q == IDX_W'(NWORDS - 1));
    // Word 0 lives in the top slice of the block.
    sel        = IDX_W'(NWORDS - 1) - word_idx_q;
    out_data   = words[sel];
    accept     = out_valid && out_ready;
    pop        = accept && out_last;
    word_idx_d = word_idx_q;
    if (pop) begin
      word_idx_d = '0;
    end else if (accept) begin
      word_idx_d = word_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_idx_q <= '0;
    end else begin
      word_idx_q <= word_idx_d;
    end
  end

endmodule

// File: rtl/aes_result_buffer.sv
// Circular queue of AES ciphertext blocks captured on the cipher's done pulse,
// drained as a word stream; flags full and sticky overflow to the producer.
module aes_result_buffer
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   done_i,
  input  aes_block_t             text_i,
  aes_result_buffer_if.master    out_if,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  aes_block_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push       = done_i && (!full || pop);
    drop       = done_i && full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= text_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  aes_word_serializer #(
    .OUT_W(OUT_W)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .head       (mem[rd_ptr_q]),
    .head_valid (count_q != '0),
    .out_ready  (out_if.out_ready),
    .out_valid  (out_if.out_valid),
    .out_data   (out_if.out_data),
    .out_last   (out_if.out_last),
    .pop        (pop)
  );

endmodule

// File: tb/tb_aes_result_buffer.sv
// Directed bench for aes_result_buffer: vector table for the single-block
// stream and backpressure, hand sequences for fill/drop, wrap and reset.
module tb_aes_result_buffer;
  import aes_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OUT_W = 32;
  localparam aes_block_t  FIPS  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic       clk = 1'b0;
  logic       rst;
  logic       done_i;
  aes_block_t text_i;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  aes_result_buffer_if #(.OUT_W(OUT_W)) bus ();

  aes_result_buffer #(
    .DEPTH(DEPTH),
    .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .done_i   (done_i),
    .text_i   (text_i),
    .out_if   (bus),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       done;
    aes_block_t text;
    logic       ready;
    logic       exp_valid;
    logic [31:0] exp_data;
    logic       exp_last;
    logic [2:0] exp_count;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic done, input aes_block_t text, input logic ready,
                              input logic ev, input logic [31:0] ed, input logic el,
                              input logic [2:0] ec);
    vec_t v;
    v.done = done; v.text = text; v.ready = ready;
    v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_count = ec;
    return v;
  endfunction

  function automatic logic [31:0] wd(input int k, input int w);
    return {8'hC0, 8'(k), 8'h5A, 8'(w)};
  endfunction

  function automatic aes_block_t blk(input int k);
    return {wd(k, 0), wd(k, 1), wd(k, 2), wd(k, 3)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] d, input logic l);
    chk({name, ".valid"}, 128'(bus.out_valid), 128'd1);
    chk({name, ".data"}, 128'(bus.out_data), 128'(d));
    chk({name, ".last"}, 128'(bus.out_last), 128'(l));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; done_i = 1'b0; text_i = '0; clr_ovf = 1'b0; bus.out_ready = 1'b0;

    vecs[0] = mk(1'b1, FIPS, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
    vecs[1] = mk(1'b0, '0, 1'b1, 1'b1, 32'h69c4e0d8, 1'b0, 3'd1);
    vecs[2] = mk(1'b0, '0, 1'b1, 1'b1, 32'h6a7b0430, 1'b0, 3'd1);
    vecs[3] = mk(1'b0, '0, 1'b1, 1'b1, 32'hd8cdb780, 1'b0, 3'd1);
    vecs[4] = mk(1'b0, '0, 1'b1, 1'b1, 32'h70b4c55a, 1'b1, 3'd1);
    vecs[5] = mk(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0);
    vecs[6] = mk(1'b1, FIPS, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0);
    for (int i = 7; i <= 11; i++) vecs[i] = mk(1'b0, '0, 1'b0, 1'b1, 32'h69c4e0d8, 1'b0, 3'd1);
    vecs[12] = mk(1'b0, '0, 1'b1, 1'b1, 32'h69c4e0d8, 1'b0, 3'd1);
    vecs[13] = mk(1'b0, '0, 1'b1, 1'b1, 32'h6a7b0430, 1'b0, 3'd1);
    vecs[14] = mk(1'b0, '0, 1'b1, 1'b1, 32'hd8cdb780, 1'b0, 3'd1);
    vecs[15] = mk(1'b0, '0, 1'b1, 1'b1, 32'h70b4c55a, 1'b1, 3'd1);
    vecs[16] = mk(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0);

    tick(); tick();
    chk("reset.valid", 128'(bus.out_valid), 128'd0);
    chk("reset.last", 128'(bus.out_last), 128'd0);
    chk("reset.full", 128'(full), 128'd0);
    chk("reset.count", 128'(count), 128'd0);
    chk("reset.overflow", 128'(overflow), 128'd0);
    rst = 1'b1;
    tick();

    // Single FIPS-197 block, then the same block held off by backpressure.
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("vec%0d.valid", i), 128'(bus.out_valid), 128'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.last", i), 128'(bus.out_last), 128'(vecs[i].exp_last));
      chk($sformatf("vec%0d.count", i), 128'(count), 128'(vecs[i].exp_count));
      chk($sformatf("vec%0d.full", i), 128'(full), 128'd0);
      chk($sformatf("vec%0d.overflow", i), 128'(overflow), 128'd0);
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d.data", i), 128'(bus.out_data), 128'(vecs[i].exp_data));
      done_i = vecs[i].done;
      text_i = vecs[i].text;
      bus.out_ready = vecs[i].ready;
      tick();
    end

    // Fill to DEPTH, drop a fifth block, drain exactly the first four.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      done_i = 1'b1; text_i = blk(k);
      tick();
      if (k == 3) begin
        chk("fill.full", 128'(full), 128'd1);
        chk("fill.count", 128'(count), 128'd4);
        chk("fill.overflow", 128'(overflow), 128'd0);
      end
    end
    done_i = 1'b0;
    chk("drop.overflow", 128'(overflow), 128'd1);
    chk("drop.count", 128'(count), 128'd4);
    chk("drop.full", 128'(full), 128'd1);
    bus.out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 4; w++) begin
        chk_word($sformatf("drain b%0d w%0d", b, w), wd(b, w), w == 3);
        tick();
      end
    end
    chk("drain.valid", 128'(bus.out_valid), 128'd0);
    chk("drain.count", 128'(count), 128'd0);
    chk("drain.overflow_sticky", 128'(overflow), 128'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr.overflow", 128'(overflow), 128'd0);

    // Push into a full buffer in the same cycle the head block pops.
    bus.out_ready = 1'b0;
    for (int k = 10; k < 14; k++) begin
      done_i = 1'b1; text_i = blk(k);
      tick();
    end
    done_i = 1'b0;
    chk("fullpop.pre_count", 128'(count), 128'd4);
    bus.out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      chk_word($sformatf("fullpop head w%0d", w), wd(10, w), 1'b0);
      tick();
    end
    chk_word("fullpop head w3", wd(10, 3), 1'b1);
    done_i = 1'b1; text_i = blk(14);
    tick();
    done_i = 1'b0;
    chk("fullpop.count", 128'(count), 128'd4);
    chk("fullpop.full", 128'(full), 128'd1);
    chk("fullpop.overflow", 128'(overflow), 128'd0);
    for (int b = 11; b < 15; b++) begin
      for (int w = 0; w < 4; w++) begin
        chk_word($sformatf("fullpop b%0d w%0d", b, w), wd(b, w), w == 3);
        tick();
      end
    end
    chk("fullpop.empty", 128'(bus.out_valid), 128'd0);

    // Ten single-block round trips push the pointers around the ring.
    for (int k = 0; k < 10; k++) begin
      done_i = 1'b1; text_i = blk(k);
      tick();
      done_i = 1'b0;
      for (int w = 0; w < 4; w++) begin
        chk($sformatf("wrap k%0d w%0d count", k, w), 128'(count), 128'd1);
        chk_word($sformatf("wrap k%0d w%0d", k, w), wd(k, w), w == 3);
        tick();
      end
    end
    chk("wrap.empty", 128'(bus.out_valid), 128'd0);

    // Drop with clr_ovf in the same cycle, then reset mid-block.
    bus.out_ready = 1'b0;
    for (int k = 30; k < 34; k++) begin
      done_i = 1'b1; text_i = blk(k);
      tick();
    end
    done_i = 1'b1; text_i = blk(34); clr_ovf = 1'b1;
    tick();
    done_i = 1'b0; clr_ovf = 1'b0;
    chk("setwins.overflow", 128'(overflow), 128'd1);
    bus.out_ready = 1'b1;
    for (int b = 30; b < 32; b++) begin
      for (int w = 0; w < 4; w++) begin
        chk_word($sformatf("prerst b%0d w%0d", b, w), wd(b, w), w == 3);
        tick();
      end
    end
    for (int w = 0; w < 2; w++) begin
      chk_word($sformatf("prerst b32 w%0d", w), wd(32, w), 1'b0);
      tick();
    end
    chk_word("prerst b32 w2", wd(32, 2), 1'b0);
    chk("prerst.count", 128'(count), 128'd2);
    #2 rst = 1'b0;
    #1;
    chk("asyncrst.valid", 128'(bus.out_valid), 128'd0);
    chk("asyncrst.count", 128'(count), 128'd0);
    chk("asyncrst.full", 128'(full), 128'd0);
    chk("asyncrst.overflow", 128'(overflow), 128'd0);
    chk("asyncrst.last", 128'(bus.out_last), 128'd0);
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    done_i = 1'b1; text_i = blk(40);
    tick();
    done_i = 1'b0;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      chk_word($sformatf("postrst w%0d", w), wd(40, w), w == 3);
      tick();
    end
    chk("postrst.empty", 128'(bus.out_valid), 128'd0);
    chk("postrst.count", 128'(count), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
